// File: rtl/clk_div_if.sv
// Control/status bundle for the reference-clock divider: enable and ratio in,
// divided clock and active ratio out.
interface clk_div_if #(
  parameter int RATIO_WIDTH = 8
);
  logic                   i_clk_en;
  logic [RATIO_WIDTH-1:0] i_div_ratio;
  logic                   o_div_clk;
  logic [RATIO_WIDTH-1:0] o_ratio_active;

  modport master (
    output i_clk_en, i_div_ratio,
    input  o_div_clk, o_ratio_active
  );

  modport slave (
    input  i_clk_en, i_div_ratio,
    output o_div_clk, o_ratio_active
  );
endinterface

// File: rtl/clk_div.sv
// Runtime-programmable integer clock divider with bypass; the ratio is taken
// into a shadow register only at period boundaries, restarts or while bypassed.
module clk_div #(
  parameter int RATIO_WIDTH = 8
) (
  input  logic CLK,
  input  logic RST,
  clk_div_if.slave bus
);
  localparam int CW = RATIO_WIDTH - 1;

  logic [CW-1:0]          counter, counter_nxt;
  logic                   div_reg, div_nxt;
  logic [RATIO_WIDTH-1:0] shadow_ratio, shadow_nxt;
  logic                   load_pending;
  logic                   en_d;

  logic          bypass, restart, phase_done, period_end, load;
  logic [CW-1:0] low_last, high_last, phase_last;

  assign bypass = !bus.i_clk_en || (shadow_ratio < RATIO_WIDTH'(2));

  // Last counter value of each phase: ceil(N/2)-1 low, floor(N/2)-1 high.
  // Modulo-2^CW arithmetic keeps N=255 correct (127+1-1 wraps back to 127).
  assign low_last   = shadow_ratio[RATIO_WIDTH-1:1] + CW'(shadow_ratio[0]) - CW'(1);
  assign high_last  = shadow_ratio[RATIO_WIDTH-1:1] - CW'(1);
  assign phase_last = div_reg ? high_last : low_last;

  assign phase_done = (counter == phase_last);
  assign period_end = !bypass && div_reg && phase_done;
  assign restart    = load_pending || (!en_d && bus.i_clk_en);
  assign load       = restart || period_end || bypass;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    counter_nxt = counter;
    div_nxt     = div_reg;
    shadow_nxt  = load ? bus.i_div_ratio : shadow_ratio;
    if (bypass || restart) begin
      counter_nxt = '0;
      div_nxt     = 1'b0;
    end else if (phase_done) begin
      counter_nxt = '0;
      div_nxt     = !div_reg;
    end else begin
      counter_nxt = counter + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      counter      <= '0;
      div_reg      <= 1'b0;
      shadow_ratio <= '0;
      load_pending <= 1'b1;
      en_d         <= 1'b0;
    end else begin
      counter      <= counter_nxt;
      div_reg      <= div_nxt;
      shadow_ratio <= shadow_nxt;
      load_pending <= 1'b0;
      en_d         <= bus.i_clk_en;
    end
  end

  // Combinational mux: in bypass the reference clock passes straight through.
  assign bus.o_div_clk      = bypass ? CLK : div_reg;
  assign bus.o_ratio_active = shadow_ratio;
endmodule

// File: tb/tb_clk_div.sv
// Directed self-checking bench for clk_div: ratios 4/5/255, bypass cases,
// mid-period ratio change, enable drop/re-raise and mid-period reset.
module tb_clk_div;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  clk_div_if #(.RATIO_WIDTH(8)) bus ();

  clk_div #(.RATIO_WIDTH(8)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Samples one value per CLK cycle, starting at the current post-edge point.
  task automatic check_wave(input string tag, input int low, input int high, input int periods);
    for (int p = 0; p < periods; p++) begin
      for (int i = 0; i < low; i++) begin
        check({tag, " low"}, 32'(bus.o_div_clk), 32'd0);
        tick();
      end
      for (int i = 0; i < high; i++) begin
        check({tag, " high"}, 32'(bus.o_div_clk), 32'd1);
        tick();
      end
    end
  endtask

  // Output must equal CLK in both halves of each cycle.
  task automatic check_bypass(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check({tag, " clk_hi"}, 32'(bus.o_div_clk), 32'd1);
      @(negedge clk);
      #1;
      check({tag, " clk_lo"}, 32'(bus.o_div_clk), 32'd0);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.i_clk_en    = 1'b1;
    bus.i_div_ratio = 8'd4;

    // Reset state: bypass, shadow cleared
    #2;
    check("reset ratio", 32'(bus.o_ratio_active), 32'd0);
    check_bypass("reset bypass", 2);

    // Ratio 4 after reset release
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ratio4 active", 32'(bus.o_ratio_active), 32'd4);
    check_wave("ratio4", 2, 2, 10);

    // Ratio 5: current period of 4 completes, then 3/2
    bus.i_div_ratio = 8'd5;
    check_wave("ratio4 tail", 2, 2, 1);
    check("ratio5 active", 32'(bus.o_ratio_active), 32'd5);
    check_wave("ratio5", 3, 2, 3);

    // Ratio 255: low 128, high 127
    bus.i_div_ratio = 8'd255;
    check_wave("ratio5 tail", 3, 2, 1);
    check("ratio255 active", 32'(bus.o_ratio_active), 32'd255);
    check_wave("ratio255", 128, 127, 1);

    // Bypass: enable low with ratio 0, then ratio 0 enabled, ratio 1, enable low with 6
    @(negedge clk);
    bus.i_clk_en    = 1'b0;
    bus.i_div_ratio = 8'd0;
    check_bypass("bypass en0", 3);
    check("bypass en0 active", 32'(bus.o_ratio_active), 32'd0);
    @(negedge clk);
    bus.i_clk_en = 1'b1;
    check_bypass("bypass r0", 3);
    @(negedge clk);
    bus.i_div_ratio = 8'd1;
    check_bypass("bypass r1", 3);
    check("bypass r1 active", 32'(bus.o_ratio_active), 32'd1);
    @(negedge clk);
    bus.i_clk_en    = 1'b0;
    bus.i_div_ratio = 8'd6;
    check_bypass("bypass r6", 3);
    check("bypass r6 active", 32'(bus.o_ratio_active), 32'd6);

    // Enable rise with ratio 4, change to 6 mid low phase
    @(negedge clk);
    bus.i_clk_en    = 1'b1;
    bus.i_div_ratio = 8'd4;
    tick();
    check("chg active4", 32'(bus.o_ratio_active), 32'd4);
    check("chg low0", 32'(bus.o_div_clk), 32'd0);
    @(negedge clk);
    bus.i_div_ratio = 8'd6;
    tick();
    check("chg low1", 32'(bus.o_div_clk), 32'd0);
    tick();
    check("chg high0", 32'(bus.o_div_clk), 32'd1);
    tick();
    check("chg high1", 32'(bus.o_div_clk), 32'd1);
    check("chg still4", 32'(bus.o_ratio_active), 32'd4);
    tick();
    check("chg active6", 32'(bus.o_ratio_active), 32'd6);
    check_wave("ratio6", 3, 3, 2);

    // Ratio 8, drop enable mid high phase, re-raise with ratio 3
    bus.i_div_ratio = 8'd8;
    check_wave("ratio6 tail", 3, 3, 1);
    check("ratio8 active", 32'(bus.o_ratio_active), 32'd8);
    check_wave("ratio8", 4, 0, 1);
    check("ratio8 high0", 32'(bus.o_div_clk), 32'd1);
    tick();
    check("ratio8 high1", 32'(bus.o_div_clk), 32'd1);
    @(negedge clk);
    bus.i_clk_en = 1'b0;
    #1;
    check("en drop follows clk", 32'(bus.o_div_clk), 32'd0);
    check_bypass("en drop", 3);
    @(negedge clk);
    bus.i_clk_en    = 1'b1;
    bus.i_div_ratio = 8'd3;
    tick();
    check("ratio3 active", 32'(bus.o_ratio_active), 32'd3);
    check_wave("ratio3", 2, 1, 3);

    // Ratio 10, reset asserted mid high phase
    bus.i_div_ratio = 8'd10;
    check_wave("ratio3 tail", 2, 1, 1);
    check("ratio10 active", 32'(bus.o_ratio_active), 32'd10);
    check_wave("ratio10", 5, 0, 1);
    check("ratio10 high0", 32'(bus.o_div_clk), 32'd1);
    tick();
    check("ratio10 high1", 32'(bus.o_div_clk), 32'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst follows clk", 32'(bus.o_div_clk), 32'd0);
    check("midrst active", 32'(bus.o_ratio_active), 32'd0);
    check_bypass("midrst bypass", 2);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rerelease active", 32'(bus.o_ratio_active), 32'd10);
    check_wave("rerelease", 5, 5, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
